alu_mc_n: RTL and testbench
===========================

Name: alu_mc_n

Overview:
- Parametrised multi-cycle successor to the single-cycle ALU.
- Executes the same base integer ops in 1 cycle, plus iterative unsigned multiply/divide (N cycles).
- Uses a valid/ready handshake on both input and output, so the MCU pipeline can stall on long ops.
- Sits between the decode/operand-fetch stage and writeback; bru_exp_o feeds branch resolution as before.

Parameters:
- N, 32, operand/result width in bits (N >= 4, power of two).
- SHW, $clog2(N), shift-amount width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  operands and op are valid this cycle.
- ready_o  out  1  block can accept a new operation.
- operand0_i  in  N  first operand (rs1).
- operand1_i  in  N  second operand (rs2/imm).
- alu_op_i  in  4  operation select.
- valid_o  out  1  alu_data_o/bru_exp_o are valid.
- ready_i  in  1  downstream accepts result.
- alu_data_o  out  N  result.
- bru_exp_o  out  1  1 when the result is non-zero, else 0.
- busy_o  out  1  iterative op in progress (state BUSY).

Behaviour:
- Reset: when rst_i=1 at an edge:
  - state <= IDLE; counter <= 0.
  - valid_o=0, alu_data_o=0, bru_exp_o=0, busy_o=0.
  - ready_o=1 from the first cycle after reset.
  - Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded and never presented.
- States IDLE, BUSY, DONE.
  - ready_o=(state==IDLE); busy_o=(state==BUSY); valid_o=(state==DONE).
- Accept: valid_i & ready_o at edge T latches operand0_i, operand1_i and alu_op_i. Inputs are ignored in all other cycles.
- Op encoding (unsigned unless stated):
  - 0 add; 1 sll; 2 slt (signed, result 0/1); 3 sltu (result 0/1); 4 xor; 5 srl; 6 or; 7 and; 8 sub (operand0-operand1).
  - 9 mul (low N bits of product); a mulhu (high N bits of 2N-bit product); b divu; c remu.
  - d sra (arithmetic right shift).
  - e, f reserved: result 0.
- Shifts use operand1[SHW-1:0] only; upper bits are ignored.
- Add/sub wrap modulo 2^N; no carry or overflow output.
- Single-cycle ops (0-8, d, e, f): IDLE -> DONE at T. Result registered; valid_o=1 in cycle T+1.
- Iterative ops (9-c): IDLE -> BUSY at T; counter loads N-1 and decrements each cycle in BUSY.
  - Multiply: shift-add, one operand bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - BUSY -> DONE when counter==0 at an edge; valid_o=1 in cycle T+N+1.
- Divide by zero (operand1=0): divu result = all ones; remu result = operand0. Latency is still N+1; no exception.
- DONE: alu_data_o and bru_exp_o stay stable while valid_o=1 and ready_i=0.
  - valid_o & ready_i at an edge -> IDLE; ready_o=1 the next cycle.
  - No same-cycle accept of a new op in DONE; maximum throughput is one op per 2 cycles.
- bru_exp_o = (alu_data_o != 0); registered with the result and valid only while valid_o=1. It is 0 in IDLE/BUSY.
- alu_data_o holds its last value in IDLE/BUSY; consumers use it only while valid_o=1.
- valid_i while BUSY/DONE: ignored; the upstream stage holds its request.

Test Plan:
- Reset, then valid_i with op=0, 0x7FFFFFFF + 0x00000001 -> valid_o at T+1, data 0x80000000, bru_exp_o=1. With ready_i=1, ready_o returns to 1 at T+2.
- op=2: slt(0xFFFFFFFF, 0x00000001) -> 1. op=3: sltu of the same operands -> 0. op=8: 5-5 -> data 0, bru_exp_o=0.
- op=d: sra(0x80000000, 0x24), shift amount 4 -> 0xF8000000. op=5: srl of the same operands -> 0x08000000. op=1: sll(1, 31) -> 0x80000000.
- op=9 and op=a: 0xFFFFFFFF * 0xFFFFFFFF -> mul 0x00000001, mulhu 0xFFFFFFFE. Each: valid_o exactly at T+33; busy_o high cycles T+1..T+32; ready_o=0 throughout.
- op=b/c: 100 / 7 -> divu 14, remu 2. 100 / 0 -> divu 0xFFFFFFFF, remu 100, both at T+33.
- Backpressure and reset:
  - Hold ready_i=0 for 5 cycles in DONE -> data stable, valid_o=1, and a valid_i pulse is ignored.
  - Assert rst_i at T+10 of a divu -> valid_o never rises; ready_o=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_mc_n_if.sv
// Operand/result handshake bundle between operand fetch and writeback for alu_mc_n.
// Signal names keep the ALU's port view; the slave modport is the ALU side.
interface alu_mc_n_if #(
    parameter int N = 32
);
    logic         valid_i;
    logic         ready_o;
    logic [N-1:0] operand0_i;
    logic [N-1:0] operand1_i;
    logic [3:0]   alu_op_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] alu_data_o;
    logic         bru_exp_o;
    logic         busy_o;

    modport slave (
        input  valid_i, operand0_i, operand1_i, alu_op_i, ready_i,
        output ready_o, valid_o, alu_data_o, bru_exp_o, busy_o
    );

    modport master (
        output valid_i, operand0_i, operand1_i, alu_op_i, ready_i,
        input  ready_o, valid_o, alu_data_o, bru_exp_o, busy_o
    );
endinterface

// File: rtl/alu_mc_n.sv
// Multi-cycle ALU: base ops in 1 cycle, iterative unsigned mul/mulhu/divu/remu in N cycles.
// Result held in DONE until ready_i; new ops are accepted only in IDLE.
module alu_mc_n #(
    parameter  int N   = 32,
    localparam int SHW = $clog2(N)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_mc_n_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_MUL   = 4'h9;
    localparam logic [3:0] OP_MULHU = 4'hA;
    localparam logic [3:0] OP_DIVU  = 4'hB;
    localparam logic [3:0] OP_REMU  = 4'hC;

    state_t         state_q;
    logic [SHW-1:0] cnt_q;
    logic [3:0]     op_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] wreg_q;
    logic [2*N-1:0] wreg_d;
    logic [N-1:0]   data_q;
    logic           bru_q;
    logic [N-1:0]   res_d;
    logic [N-1:0]   it_res_d;
    logic [SHW-1:0] shamt;
    logic           is_iter;
    logic [N:0]     mul_sum;
    logic [N:0]     div_sh;
    logic [N:0]     div_diff;
    logic           div_ge;

    assign shamt   = bus.operand1_i[SHW-1:0];
    assign is_iter = (bus.alu_op_i >= OP_MUL) && (bus.alu_op_i <= OP_REMU);

    always_comb begin
        res_d = '0;
        case (bus.alu_op_i)
            4'h0: res_d = bus.operand0_i + bus.operand1_i;
            4'h1: res_d = bus.operand0_i << shamt;
            4'h2: res_d = {{(N-1){1'b0}}, $signed(bus.operand0_i) < $signed(bus.operand1_i)};
            4'h3: res_d = {{(N-1){1'b0}}, bus.operand0_i < bus.operand1_i};
            4'h4: res_d = bus.operand0_i ^ bus.operand1_i;
            4'h5: res_d = bus.operand0_i >> shamt;
            4'h6: res_d = bus.operand0_i | bus.operand1_i;
            4'h7: res_d = bus.operand0_i & bus.operand1_i;
            4'h8: res_d = bus.operand0_i - bus.operand1_i;
            4'hD: res_d = $signed(bus.operand0_i) >>> shamt;
            default: res_d = '0;
        endcase
    end

    // wreg_q is {acc, multiplier} for multiply and {remainder, quotient} for divide,
    // so low half gives mul/divu and high half gives mulhu/remu.
    always_comb begin
        mul_sum  = {1'b0, wreg_q[2*N-1:N]} + (wreg_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {wreg_q[2*N-1:N], wreg_q[N-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_diff = div_sh - {1'b0, b_q};
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            wreg_d = {mul_sum, wreg_q[N-1:1]};
        end else begin
            wreg_d = {(div_ge ? div_diff[N-1:0] : div_sh[N-1:0]), wreg_q[N-2:0], div_ge};
        end
        it_res_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? wreg_d[N-1:0] : wreg_d[2*N-1:N];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            wreg_q  <= '0;
            data_q  <= '0;
            bru_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_q <= bus.alu_op_i;
                        if (is_iter) begin
                            b_q     <= bus.operand1_i;
                            wreg_q  <= {{N{1'b0}}, bus.operand0_i};
                            cnt_q   <= SHW'(N - 1);
                            state_q <= BUSY;
                        end else begin
                            data_q  <= res_d;
                            bru_q   <= (res_d != '0);
                            state_q <= DONE;
                        end
                    end
                end
                BUSY: begin
                    wreg_q <= wreg_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        data_q  <= it_res_d;
                        bru_q   <= (it_res_d != '0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        bru_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.busy_o     = (state_q == BUSY);
    assign bus.valid_o    = (state_q == DONE);
    assign bus.alu_data_o = data_q;
    assign bus.bru_exp_o  = bru_q;
endmodule

// File: tb/tb_alu_mc_n.sv
// Directed-vector bench for alu_mc_n: latency, results, handshake, backpressure and reset abort.
module tb_alu_mc_n;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    alu_mc_n_if #(.N(32)) bus ();

    alu_mc_n #(.N(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Issue one op with ready_i=1, then check latency, result, busy/ready profile and return to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want, input int want_lat);
        int lat;
        int nbusy;
        int nrdy;
        @(negedge clk);
        bus.ready_i    = 1'b1;
        bus.valid_i    = 1'b1;
        bus.alu_op_i   = op;
        bus.operand0_i = a;
        bus.operand1_i = b;
        @(posedge clk);
        #1;
        bus.valid_i    = 1'b0;
        bus.alu_op_i   = 4'h4;
        bus.operand0_i = 32'hDEADBEEF;
        bus.operand1_i = 32'h12345678;
        lat   = 1;
        nbusy = 0;
        nrdy  = 0;
        @(negedge clk);
        while (!bus.valid_o && lat < 100) begin
            nbusy += int'(bus.busy_o);
            nrdy  += int'(bus.ready_o);
            if (bus.bru_exp_o) nrdy++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(want_lat));
        check_eq({tag, "_data"}, bus.alu_data_o, want);
        check_eq({tag, "_bru"}, {31'b0, bus.bru_exp_o}, {31'b0, want != 32'h0});
        check_eq({tag, "_ready_in_done"}, {31'b0, bus.ready_o}, 32'h0);
        if (want_lat > 1) begin
            check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'(want_lat - 1));
            check_eq({tag, "_ready_or_bru_while_busy"}, 32'(nrdy), 32'h0);
        end
        @(negedge clk);
        check_eq({tag, "_ready_after"}, {31'b0, bus.ready_o}, 32'h1);
        check_eq({tag, "_valid_after"}, {31'b0, bus.valid_o}, 32'h0);
        check_eq({tag, "_bru_after"}, {31'b0, bus.bru_exp_o}, 32'h0);
    endtask

    initial begin
        int vcount;
        n_chk          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.valid_i    = 1'b0;
        bus.ready_i    = 1'b1;
        bus.alu_op_i   = 4'h0;
        bus.operand0_i = 32'h0;
        bus.operand1_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        check_eq("rst_data", bus.alu_data_o, 32'h0);
        check_eq("rst_bru", {31'b0, bus.bru_exp_o}, 32'h0);
        check_eq("rst_busy", {31'b0, bus.busy_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'b0, bus.ready_o}, 32'h1);

        run_op("add",      4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        run_op("add_wrap", 4'h0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1);
        run_op("slt",      4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        run_op("sltu",     4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        run_op("sub",      4'h8, 32'h00000005, 32'h00000005, 32'h00000000, 1);
        run_op("sra",      4'hD, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
        run_op("srl",      4'h5, 32'h80000000, 32'h00000024, 32'h08000000, 1);
        run_op("sll",      4'h1, 32'h00000001, 32'h0000001F, 32'h80000000, 1);
        run_op("xor",      4'h4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
        run_op("or",       4'h6, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1);
        run_op("and",      4'h7, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
        run_op("rsvd_e",   4'hE, 32'h00000005, 32'h00000003, 32'h00000000, 1);
        run_op("rsvd_f",   4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("mul",      4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        run_op("mulhu",    4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mul_small",4'h9, 32'h00001234, 32'h00000100, 32'h00123400, 33);
        run_op("divu",     4'hB, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu",     4'hC, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_z",   4'hB, 32'd100, 32'd0, 32'hFFFFFFFF, 33);
        run_op("remu_z",   4'hC, 32'd100, 32'd0, 32'd100, 33);

        // Backpressure: hold ready_i low in DONE, pulse valid_i, result must not move.
        @(negedge clk);
        bus.ready_i    = 1'b0;
        bus.valid_i    = 1'b1;
        bus.alu_op_i   = 4'h6;
        bus.operand0_i = 32'h00A0_0000;
        bus.operand1_i = 32'h0000_000B;
        @(negedge clk);
        bus.valid_i = 1'b0;
        check_eq("bp_valid_first", {31'b0, bus.valid_o}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.valid_i    = 1'b1;
                bus.alu_op_i   = 4'h0;
                bus.operand0_i = 32'h1;
                bus.operand1_i = 32'h1;
            end else begin
                bus.valid_i = 1'b0;
            end
            @(negedge clk);
            check_eq("bp_valid_hold", {31'b0, bus.valid_o}, 32'h1);
            check_eq("bp_data_hold", bus.alu_data_o, 32'h00A0000B);
            check_eq("bp_bru_hold", {31'b0, bus.bru_exp_o}, 32'h1);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        check_eq("bp_ready_after", {31'b0, bus.ready_o}, 32'h1);
        @(negedge clk);
        check_eq("bp_no_ghost_op", {31'b0, bus.valid_o}, 32'h0);
        check_eq("bp_data_kept", bus.alu_data_o, 32'h00A0000B);

        // Reset during a divide: result must never appear.
        bus.ready_i    = 1'b1;
        bus.valid_i    = 1'b1;
        bus.alu_op_i   = 4'hB;
        bus.operand0_i = 32'd100;
        bus.operand1_i = 32'd7;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("abort_busy_before", {31'b0, bus.busy_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", {31'b0, bus.ready_o}, 32'h1);
        check_eq("abort_busy", {31'b0, bus.busy_o}, 32'h0);
        check_eq("abort_data", bus.alu_data_o, 32'h0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vcount += int'(bus.valid_o);
        end
        check_eq("abort_never_valid", 32'(vcount), 32'h0);

        run_op("post_rst_add", 4'h0, 32'h00000010, 32'h00000020, 32'h00000030, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
